// File: rtl/approx_error_monitor.sv
// approx_error_monitor
//   Consumes one (exact, approximate) partition output pair per input vector and
//   accumulates error statistics over a full input sweep of 2**IN_W vectors:
//   error count, summed Hamming distance, summed absolute error and the largest
//   absolute error. Sits after an exact/approximate partition pair in the
//   on-chip evaluation harness.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      pulse: clear statistics and begin a sweep (ignored in RUN)
//   in_valid     in   1      exact_po/approx_po carry one vector's results
//   in_ready     out  1      monitor can accept a pair (high only in RUN)
//   exact_po     in   OUT_W  golden partition output, unsigned
//   approx_po    in   OUT_W  approximate partition output, unsigned
//   busy         out  1      sweep in progress (RUN)
//   done         out  1      sweep complete, statistics final (DONE)
//   vec_cnt      out  CNT_W  pairs accepted in current sweep
//   err_cnt      out  CNT_W  pairs with approx_po != exact_po
//   hd_sum       out  SUM_W  sum of popcount(approx_po ^ exact_po)
//   abs_err_sum  out  SUM_W  sum of |approx_po - exact_po|
//   max_abs_err  out  OUT_W  largest |approx_po - exact_po| this sweep
//
// Handshake: a pair transfers on a rising edge where in_valid and in_ready are
// both high. in_ready depends only on the registered state, never on in_valid,
// and in_valid is ignored whenever in_ready is low. The producer may insert
// gaps freely; there is no timeout.
//
// FSM state is fully observable on busy/done: IDLE = !busy & !done,
// RUN = busy, DONE = done.

module approx_error_monitor #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4,
    parameter int CNT_W = IN_W + 1,
    parameter int SUM_W = IN_W + OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] exact_po,
    input  logic [OUT_W-1:0] approx_po,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] hd_sum,
    output logic [SUM_W-1:0] abs_err_sum,
    output logic [OUT_W-1:0] max_abs_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // vec_cnt value when the final vector of the sweep is being accepted
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << IN_W) - 1);

    state_t state, state_next;

    logic             accept;
    logic             sweep_start;
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] ae;
    logic [SUM_W-1:0] pop;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign accept      = in_valid & in_ready;
    assign sweep_start = start & (state != RUN);
    assign diff        = approx_po ^ exact_po;

    // Absolute difference of unsigned operands; the result always fits OUT_W bits.
    always_comb begin
        ae = '0;
        if (approx_po >= exact_po) begin
            ae = approx_po - exact_po;
        end else begin
            ae = exact_po - approx_po;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pop = pop + SUM_W'(diff[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // The final accept updates statistics and enters DONE on the same edge.
                if (accept && (vec_cnt == LAST_IDX)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt     <= '0;
            err_cnt     <= '0;
            hd_sum      <= '0;
            abs_err_sum <= '0;
            max_abs_err <= '0;
        end else if (sweep_start) begin
            vec_cnt     <= '0;
            err_cnt     <= '0;
            hd_sum      <= '0;
            abs_err_sum <= '0;
            max_abs_err <= '0;
        end else if (accept) begin
            vec_cnt     <= vec_cnt + CNT_W'(1);
            err_cnt     <= err_cnt + CNT_W'(diff != '0);
            hd_sum      <= hd_sum + pop;
            abs_err_sum <= abs_err_sum + SUM_W'(ae);
            if (ae > max_abs_err) begin
                max_abs_err <= ae;
            end
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor
//   Directed/randomized bench for approx_error_monitor. Every accepted pair is
//   recorded in a queue; expected statistics are recomputed from the whole queue
//   with plain arithmetic whenever the statistics are checked.

module tb_approx_error_monitor;

    localparam int IN_W  = 7;
    localparam int OUT_W = 4;
    localparam int CNT_W = IN_W + 1;
    localparam int SUM_W = IN_W + OUT_W;
    localparam int N     = 1 << IN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] exact_po = '0;
    logic [OUT_W-1:0] approx_po = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [SUM_W-1:0] hd_sum;
    logic [SUM_W-1:0] abs_err_sum;
    logic [OUT_W-1:0] max_abs_err;

    int n_tests = 0;
    int n_fail  = 0;

    // pairs accepted in the current sweep (exact side / approximate side)
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] apx_q[$];

    approx_error_monitor #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .exact_po(exact_po), .approx_po(approx_po), .busy(busy), .done(done),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .hd_sum(hd_sum),
        .abs_err_sum(abs_err_sum), .max_abs_err(max_abs_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        int err, hd, abs_sum, mx, e, a, ae;
        err = 0; hd = 0; abs_sum = 0; mx = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = int'(exp_q[i]);
            a = int'(apx_q[i]);
            if (e != a) err++;
            hd += $countones(exp_q[i] ^ apx_q[i]);
            ae = (a > e) ? a - e : e - a;
            abs_sum += ae;
            if (ae > mx) mx = ae;
        end
        check({tag, ".vec_cnt"},     32'(vec_cnt),     32'(exp_q.size()));
        check({tag, ".err_cnt"},     32'(err_cnt),     32'(err));
        check({tag, ".hd_sum"},      32'(hd_sum),      32'(hd));
        check({tag, ".abs_err_sum"}, 32'(abs_err_sum), 32'(abs_sum));
        check({tag, ".max_abs_err"}, 32'(max_abs_err), 32'(mx));
    endtask

    task automatic check_state(input string tag, input logic b, input logic d);
        check({tag, ".busy"},     32'(busy),     32'(b));
        check({tag, ".done"},     32'(done),     32'(d));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(b));
    endtask

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.delete();
        apx_q.delete();
    endtask

    task automatic send(input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] a,
                        input int gap, input logic with_start);
        int k;
        repeat (gap) @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid  = 1'b1;
            exact_po  = e;
            approx_po = a;
            start     = with_start;
            @(negedge clk);
            in_valid  = 1'b0;
            start     = 1'b0;
            exp_q.push_back(e);
            apx_q.push_back(a);
        end
    endtask

    task automatic pulse_valid(input int cycles);
        in_valid  = 1'b1;
        exact_po  = 4'hF;
        approx_po = 4'h0;
        repeat (cycles) @(negedge clk);
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pos;
        logic [OUT_W-1:0] r;

        // 1: reset, idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_state("s1", 1'b0, 1'b0);
        check_stats("s1");

        // 2: clean sweep, approx == exact
        do_start();
        check_state("s2.run", 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i == 1) check("s2.latency.vec_cnt", 32'(vec_cnt), 32'd1);
            if (i == N - 1) check("s2.pre_last.done", 32'(done), 32'd0);
            send(OUT_W'(i % 16), OUT_W'(i % 16), 0, 1'b0);
        end
        check_state("s2.done", 1'b0, 1'b1);
        check_stats("s2");

        // 3: LSB flipped on every vector
        do_start();
        for (int i = 0; i < N; i++) send(OUT_W'(i % 16), OUT_W'(i % 16) ^ 4'b0001, 0, 1'b0);
        check_state("s3.done", 1'b0, 1'b1);
        check_stats("s3");
        check("s3.abs_err_sum.const", 32'(abs_err_sum), 32'd128);

        // 4: random equal pairs plus one worst-case 0xF vs 0x0
        do_start();
        pos = $urandom_range(N - 1, 0);
        for (int i = 0; i < N; i++) begin
            r = OUT_W'($urandom);
            if (i == pos) send(4'hF, 4'h0, 0, 1'b0);
            else          send(r, r, 0, 1'b0);
        end
        check_state("s4.done", 1'b0, 1'b1);
        check_stats("s4");
        check("s4.max_abs_err.const", 32'(max_abs_err), 32'd15);
        pulse_valid(3);
        check_stats("s4.done_hold");

        // 5: in_valid while IDLE, random data with gaps, start pulses mid-run
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        apx_q.delete();
        pulse_valid(4);
        check_state("s5.idle", 1'b0, 1'b0);
        check_stats("s5.idle");
        do_start();
        for (int i = 0; i < N; i++) begin
            if (i == 90) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (i == N - 1) check("s5.pre_last.done", 32'(done), 32'd0);
            send(OUT_W'($urandom), OUT_W'($urandom), $urandom_range(3, 0), i == 60);
        end
        check_state("s5.done", 1'b0, 1'b1);
        check_stats("s5");

        // 6: reset mid-sweep, then a fresh sweep, then restart from DONE
        do_start();
        for (int i = 0; i < 50; i++) send(OUT_W'(i % 16), OUT_W'(i % 16) ^ 4'b0001, 0, 1'b0);
        check_stats("s6.partial");
        rst = 1'b1;
        #1;
        exp_q.delete();
        apx_q.delete();
        check_state("s6.rst", 1'b0, 1'b0);
        check_stats("s6.rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("s6.idle", 1'b0, 1'b0);
        do_start();
        for (int i = 0; i < N; i++) send(OUT_W'(i % 16), OUT_W'(i % 16) ^ 4'b0001, 0, 1'b0);
        check_state("s6.done", 1'b0, 1'b1);
        check_stats("s6.full");
        check("s6.hd_sum.const", 32'(hd_sum), 32'd128);
        do_start();
        check_state("s6.restart", 1'b1, 1'b0);
        check_stats("s6.restart");
        for (int i = 0; i < 10; i++) send(OUT_W'($urandom), OUT_W'($urandom), $urandom_range(2, 0), 1'b0);
        check_stats("s6.after10");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
